i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 196 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C slave with a byte-wide register file behind an auto-incrementing pointer.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scl,
    inout  wire                         sda,
    output logic                        busy,
    output logic                        reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
    output logic [7:0]                  reg_wr_data
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t          state;
    logic            scl_s1, scl_s2, sda_s1, sda_s2;
    logic            scl_f, sda_f, scl_d, sda_d;
    logic            sda_oe;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic            rw;
    logic            ack_on;
    logic            nack;
    logic [AW-1:0]   ptr;
    logic [7:0]      regs [NUM_REGS];
    logic [7:0]      rx_byte;
    logic            scl_rise, scl_fall, start_det, stop_det;

    // Open-drain output: only ever pull low or release
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers, idle-high like the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    // Majority of the current and two previous samples; single-clk pulses never win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_s2};
            sda_h <= {sda_h[0], sda_s2};
            scl_f <= (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    // Previous-sample registers for edge and START/STOP detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign rx_byte   = {shift, sda_f};

    // Protocol FSM: receive on SCL rise, change SDA drive only on SCL fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= 8'h00;
            bit_cnt     <= 3'd0;
            shift       <= 7'd0;
            rw          <= 1'b0;
            ack_on      <= 1'b0;
            nack        <= 1'b0;
            ptr         <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            reg_wr_en <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                ack_on <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
            end else if (scl_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (state == ADDR || state == PTR || state == WDATA) shift <= rx_byte[6:0];
                case (state)
                    ADDR: if (bit_cnt == 3'd7) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            state <= ADDR_ACK;
                            rw    <= rx_byte[0];
                            busy  <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    PTR: if (bit_cnt == 3'd7) begin
                        ptr   <= rx_byte[AW-1:0];
                        state <= PTR_ACK;
                    end
                    WDATA: if (bit_cnt == 3'd7) begin
                        regs[ptr]   <= rx_byte;
                        reg_wr_en   <= 1'b1;
                        reg_wr_addr <= ptr;
                        reg_wr_data <= rx_byte;
                        ptr         <= ptr + AW'(1);
                        state       <= WDATA_ACK;
                    end
                    RACK: begin
                        nack <= sda_f;
                        ptr  <= ptr + AW'(1);
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (!ack_on) begin
                            ack_on <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                state  <= RDATA;
                                shift  <= regs[ptr][6:0];
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                state  <= (state == ADDR_ACK) ? PTR : WDATA;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RDATA: begin
                        if (bit_cnt == 3'd0) begin
                            state  <= RACK;
                            sda_oe <= 1'b0;
                        end else begin
                            sda_oe <= ~shift[6];
                            shift  <= {shift[5:0], 1'b0};
                        end
                    end
                    RACK: begin
                        if (!nack) begin
                            state   <= RDATA;
                            bit_cnt <= 3'd0;
                            shift   <= regs[ptr][6:0];
                            sda_oe  <= ~regs[ptr][7];
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master model plus write-port monitor.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam int Q = 100;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_sda;
    wire        sda;
    logic       busy;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       sda_line;

    int n_checks = 0;
    int n_errors = 0;

    int         wr_cnt = 0;
    logic [7:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    int         low_cnt = 0;
    logic       watch = 1'b0;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;
    assign sda_line = (sda !== 1'b0);

    i2c_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl),
        .sda         (sda),
        .busy        (busy),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every write pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && reg_wr_en) begin
            wr_addr_log[wr_cnt % 64] = 8'(reg_wr_addr);
            wr_data_log[wr_cnt % 64] = reg_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    // Count clocks where the slave pulls the line low while the master releases it
    always @(negedge clk) begin
        if (watch && m_sda && !sda_line) low_cnt = low_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_sda = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            #Q m_sda = b[i];
            #Q scl = 1'b1;
            if (glitch && i == 7) begin
                #Q;
                @(negedge clk) scl = 1'b0;
                @(negedge clk) scl = 1'b1;
                #Q scl = 1'b0;
            end else begin
                #(2 * Q) scl = 1'b0;
            end
        end
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q ack = sda_line;
        #Q scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            #Q m_sda = 1'b1;
            #Q scl = 1'b1;
            #Q r[i] = sda_line;
            #Q scl = 1'b0;
        end
        #Q m_sda = nack;
        #Q scl = 1'b1;
        #(2 * Q) scl = 1'b0;
        b = r;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         wr0;
        int         low0;

        rst_n = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        #100;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_sda", 32'(sda_line), 32'd1);
        #100 rst_n = 1'b1;
        #400;

        // Single write: S A0 03 5A P
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("w1_addr_ack", 32'(ack), 32'd0);
        check("w1_busy_on", 32'(busy), 32'd1);
        write_byte(8'h03, 1'b0, ack); check("w1_ptr_ack", 32'(ack), 32'd0);
        write_byte(8'h5A, 1'b0, ack); check("w1_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        #(2 * Q);
        check("w1_busy_off", 32'(busy), 32'd0);
        check("w1_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("w1_wr_addr", 32'(wr_addr_log[wr0 % 64]), 32'h03);
        check("w1_wr_data", 32'(wr_data_log[wr0 % 64]), 32'h5A);

        // Pointer set, repeated START, two-byte read
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("r1_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h03, 1'b0, ack); check("r1_ptr_ack", 32'(ack), 32'd0);
        i2c_rstart();
        write_byte(8'hA1, 1'b0, ack); check("r1_raddr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, rd); check("r1_byte0", 32'(rd), 32'h5A);
        read_byte(1'b1, rd); check("r1_byte1", 32'(rd), 32'h00);
        #Q check("r1_sda_released", 32'(sda_line), 32'd1);
        #Q check("r1_sda_released2", 32'(sda_line), 32'd1);
        i2c_stop();
        #(2 * Q);

        // Wrong address 0x51: slave must stay silent
        wr0  = wr_cnt;
        low0 = low_cnt;
        watch = 1'b1;
        i2c_start();
        write_byte(8'hA2, 1'b0, ack); check("na_addr_nack", 32'(ack), 32'd1);
        check("na_busy", 32'(busy), 32'd0);
        write_byte(8'h55, 1'b0, ack); check("na_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        watch = 1'b0;
        #(2 * Q);
        check("na_sda_low_clks", 32'(low_cnt - low0), 32'd0);
        check("na_wr_count", 32'(wr_cnt - wr0), 32'd0);
        check("na_busy_end", 32'(busy), 32'd0);

        // Pointer wrap: 15 then 0
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h0F, 1'b0, ack); check("wr_ptr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, 1'b0, ack); check("wr_d0_ack", 32'(ack), 32'd0);
        write_byte(8'h22, 1'b0, ack); check("wr_d1_ack", 32'(ack), 32'd0);
        i2c_stop();
        #(2 * Q);
        check("wr_count", 32'(wr_cnt - wr0), 32'd2);
        check("wr_addr0", 32'(wr_addr_log[wr0 % 64]), 32'h0F);
        check("wr_data0", 32'(wr_data_log[wr0 % 64]), 32'h11);
        check("wr_addr1", 32'(wr_addr_log[(wr0 + 1) % 64]), 32'h00);
        check("wr_data1", 32'(wr_data_log[(wr0 + 1) % 64]), 32'h22);

        // 1-clk scl low glitch during the pointer byte, then read back reg[ptr]
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("gl_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h0F, 1'b1, ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("gl_ptr_ack", 32'(ack), 32'd0);
`else
        check("gl_ptr_ack", 32'(ack), 32'd1);
`endif
        i2c_stop();
        #(2 * Q);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("gl_raddr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("gl_read_ptr15", 32'(rd), 32'h11);
`else
        check("gl_read_ptr7", 32'(rd), 32'h00);
`endif
        i2c_stop();
        #(2 * Q);

        // Reset while the slave drives a 0 data bit
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("rr_addr_ack", 32'(ack), 32'd0);
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q check("rr_bit7_low", 32'(sda_line), 32'd0);
        rst_n = 1'b0;
        #1 check("rr_sda_async", 32'(sda_line), 32'd1);
        check("rr_busy", 32'(busy), 32'd0);
        #(4 * Q - 1) rst_n = 1'b1;
        #(4 * Q);
        check("rr_idle_sda", 32'(sda_line), 32'd1);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("rr2_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd); check("rr2_byte", 32'(rd), 32'h00);
        i2c_stop();
        #(2 * Q);
        check("rr2_busy_off", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
